// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-side program counter. Steps by 4 on each fetch handshake,
//            redirects through an external registered offset adder, and
//            vectors to TRAP_VECTOR on a trap request.
// Options  : define PC_ALIGN_CHECK_EN to trap misaligned branch targets in
//            a sticky FAULT state instead of silently aligning them.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] pc_out,
  input  logic        branch_req,
  output logic        branch_ready,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] target_in,
  input  logic        trap_req,
  output logic        misalign_fault
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_wait  = 2'd1;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [1:0] c_st_fault = 2'd2;
`endif

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_fetch_valid;
  logic        r_misalign_fault;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_fetch_valid_nxt;
  logic        w_misalign_fault_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= c_st_run;
      r_pc             <= RESET_VECTOR;
      r_fetch_valid    <= 1'b0;
      r_misalign_fault <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_fetch_valid    <= w_fetch_valid_nxt;
      r_misalign_fault <= w_misalign_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_pc_nxt             = r_pc;
    w_fetch_valid_nxt    = r_fetch_valid;
    w_misalign_fault_nxt = r_misalign_fault;
    if (trap_req) begin
      w_state_nxt          = c_st_run;
      w_pc_nxt             = TRAP_VECTOR;
      w_fetch_valid_nxt    = 1'b1;
      w_misalign_fault_nxt = 1'b0;
    end else begin
      case (r_state)
        c_st_run: begin
          // A branch wins over a same-cycle handshake: old PC is consumed, no +4.
          if (branch_req) begin
            w_state_nxt       = c_st_wait;
            w_fetch_valid_nxt = 1'b0;
          end else begin
            w_fetch_valid_nxt = 1'b1;
            if (r_fetch_valid && fetch_ready) begin
              w_pc_nxt = r_pc + 32'd4;
            end
          end
        end
        c_st_wait: begin
`ifdef PC_ALIGN_CHECK_EN
          w_pc_nxt = target_in;
          if (target_in[1:0] != 2'b00) begin
            w_state_nxt          = c_st_fault;
            w_fetch_valid_nxt    = 1'b0;
            w_misalign_fault_nxt = 1'b1;
          end else begin
            w_state_nxt       = c_st_run;
            w_fetch_valid_nxt = 1'b1;
          end
`else
          w_pc_nxt          = {target_in[31:2], 2'b00};
          w_state_nxt       = c_st_run;
          w_fetch_valid_nxt = 1'b1;
`endif
        end
`ifdef PC_ALIGN_CHECK_EN
        c_st_fault: begin
          w_fetch_valid_nxt = 1'b0;
        end
`endif
        default: begin
          w_state_nxt       = c_st_run;
          w_fetch_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    branch_ready   = (r_state == c_st_run);
    adder_a        = branch_pc;
    adder_b        = branch_offset;
    fetch_valid    = r_fetch_valid;
    pc_out         = r_pc;
    misalign_fault = r_misalign_fault;
  end

`ifndef PC_ALIGN_CHECK_EN
  // Low target bits are dropped when alignment checking is compiled out.
  logic [1:0] w_unused_tgt_lsbs;
  assign w_unused_tgt_lsbs = target_in[1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed plus randomized bench for pc_sequencer with an
//            abstract reference model of the fetch PC.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] pc_out;
  logic        branch_req;
  logic        branch_ready;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic [31:0] target_in;
  logic        trap_req;
  logic        misalign_fault;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC view, not the RTL's state encoding.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_waiting;
  logic        m_fault;
  logic [31:0] m_target;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0010)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .pc_out        (pc_out),
    .branch_req    (branch_req),
    .branch_ready  (branch_ready),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .adder_a       (adder_a),
    .adder_b       (adder_b),
    .target_in     (target_in),
    .trap_req      (trap_req),
    .misalign_fault(misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External clocked offset adder.
  initial target_in = 32'h0;
  always @(posedge clk) target_in <= adder_a + adder_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_valid   = 1'b0;
    m_waiting = 1'b0;
    m_fault   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"},    pc_out,               m_pc);
    chk({tag, ".valid"}, {31'd0, fetch_valid},  {31'd0, m_valid});
    chk({tag, ".bready"},{31'd0, branch_ready}, {31'd0, !m_waiting && !m_fault});
    chk({tag, ".fault"}, {31'd0, misalign_fault}, {31'd0, m_fault});
  endtask

  // One clock: drive inputs, check pass-through, advance model, check outputs.
  task automatic cycle(input string tag, input logic br, input logic rdy, input logic trap,
                       input logic [31:0] bpc, input logic [31:0] boff, input logic full);
    logic [31:0] t;
    branch_req    = br;
    fetch_ready   = rdy;
    trap_req      = trap;
    branch_pc     = bpc;
    branch_offset = boff;
    #1;
    if (full) begin
      chk({tag, ".adder_a"}, adder_a, bpc);
      chk({tag, ".adder_b"}, adder_b, boff);
    end
    if (trap) begin
      m_pc = 32'h10; m_valid = 1'b1; m_waiting = 1'b0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (m_waiting) begin
      t = m_target;
      m_waiting = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      m_pc = t;
      if (t % 4 != 0) begin m_fault = 1'b1; m_valid = 1'b0; end
      else m_valid = 1'b1;
`else
      m_pc    = t - (t % 4);
      m_valid = 1'b1;
`endif
    end else if (br) begin
      m_waiting = 1'b1;
      m_valid   = 1'b0;
      m_target  = bpc + boff;
    end else begin
      if (m_valid && rdy) m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    branch_req = 1'b0; fetch_ready = 1'b0; trap_req = 1'b0;
    branch_pc = 32'h0; branch_offset = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");

    // Release and stream 0,4,8.
    reset_n = 1'b1;
    cycle("rel0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("first_pc", pc_out, 32'h0);
    cycle("rel1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle("rel2", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("pc_is_8", pc_out, 32'h8);

    // Backpressure hold at 8, then resume to C.
    for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("stall_pc", pc_out, 32'h8);
    cycle("resume", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("resume_pc", pc_out, 32'hC);

    // Branch 100 + (-16) with a same-cycle handshake.
    cycle("br_req", 1'b1, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFF0, 1'b1);
    chk("br_hold_pc", pc_out, 32'hC);
    cycle("br_wait", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("br_target", pc_out, 32'hF0);
    chk("br_valid", {31'd0, fetch_valid}, 32'd1);

    // Trap during the wait cycle discards the branch.
    cycle("tr_req", 1'b1, 1'b0, 1'b0, 32'h400, 32'h40, 1'b1);
    cycle("tr_trap", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("trap_pc", pc_out, 32'h10);

    // Wrap from FFFF_FFFC.
    cycle("wr_req", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'hC, 1'b1);
    cycle("wr_wait", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap_start", pc_out, 32'hFFFF_FFFC);
    cycle("wr_step", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap_pc", pc_out, 32'h0);

    // Misaligned target 0x202.
    cycle("ma_req", 1'b1, 1'b0, 1'b0, 32'h200, 32'h2, 1'b1);
    cycle("ma_wait", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle("ma_hold0", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle("ma_hold1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle("ma_trap", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);

    // Reset asserted while waiting for a target.
    cycle("rs_req", 1'b1, 1'b1, 1'b0, 32'h8000, 32'h80, 1'b1);
    branch_req = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state("rs_async");
    #1;
    reset_n = 1'b1;
    cycle("rs_after", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rs_no_late_tgt", pc_out, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      cycle("rand",
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0),
            $urandom() & 32'hFFFF_FFF0 | ($urandom_range(0, 3) == 0 ? 32'h2 : 32'h0),
            $urandom(),
            1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
